// File: rtl/gpio_scan_pkg.sv
// Shared constants for the GPIO scan responder: field widths, frame length,
// bit offsets of every field inside the 112-bit frame, and the FSM state type.
package gpio_scan_pkg;

  localparam int SEL_WIDTH   = 4;
  localparam int ADDR_WIDTH  = 16;
  localparam int DATA_WIDTH  = 32;
  localparam int WMASK_WIDTH = 4;

  localparam int PORT_LEN  = ADDR_WIDTH + DATA_WIDTH + 2 + WMASK_WIDTH;
  localparam int SCAN_LEN  = SEL_WIDTH + 2 * PORT_LEN;
  localparam int CNT_WIDTH = 7;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = 7'd127;
  localparam logic [CNT_WIDTH-1:0] CNT_FULL = 7'(SCAN_LEN);

  // Frame layout MSB->LSB: sel, addr0, din0, csb0, web0, wmask0, addr1, din1, csb1, web1, wmask1
  localparam int SEL_MSB    = SCAN_LEN - 1;
  localparam int SEL_LSB    = SEL_MSB - SEL_WIDTH + 1;
  localparam int ADDR0_MSB  = SEL_LSB - 1;
  localparam int ADDR0_LSB  = ADDR0_MSB - ADDR_WIDTH + 1;
  localparam int DIN0_MSB   = ADDR0_LSB - 1;
  localparam int DIN0_LSB   = DIN0_MSB - DATA_WIDTH + 1;
  localparam int CSB0_BIT   = DIN0_LSB - 1;
  localparam int WEB0_BIT   = CSB0_BIT - 1;
  localparam int WMASK0_MSB = WEB0_BIT - 1;
  localparam int WMASK0_LSB = WMASK0_MSB - WMASK_WIDTH + 1;
  localparam int ADDR1_MSB  = WMASK0_LSB - 1;
  localparam int ADDR1_LSB  = ADDR1_MSB - ADDR_WIDTH + 1;
  localparam int DIN1_MSB   = ADDR1_LSB - 1;
  localparam int DIN1_LSB   = DIN1_MSB - DATA_WIDTH + 1;
  localparam int CSB1_BIT   = DIN1_LSB - 1;
  localparam int WEB1_BIT   = CSB1_BIT - 1;
  localparam int WMASK1_MSB = WEB1_BIT - 1;
  localparam int WMASK1_LSB = WMASK1_MSB - WMASK_WIDTH + 1;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_CAPTURE = 1'b1
  } scan_state_e;

endpackage

// File: rtl/gpio_scan_ctrl.sv
// GPIO scan responder: shifts in a command frame, fires one dual-port SRAM
// access per global_csb strobe, captures read data and reloads it for scan-out.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | shifting / waiting; access edge taken when armed and strobed
// ST_CAPTURE | one cycle after the access edge; dout registered at its end
module gpio_scan_ctrl
  import gpio_scan_pkg::*;
(
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_scan_en,
  input  logic                   i_scan_in,
  input  logic                   i_sram_load,
  input  logic                   i_global_csb,
  output logic                   o_scan_out,
  output logic                   o_frame_err,
  output logic [SEL_WIDTH-1:0]   o_sram_sel,
  output logic                   o_csb0,
  output logic                   o_web0,
  output logic [WMASK_WIDTH-1:0] o_wmask0,
  output logic [ADDR_WIDTH-1:0]  o_addr0,
  output logic [DATA_WIDTH-1:0]  o_din0,
  output logic                   o_csb1,
  output logic                   o_web1,
  output logic [WMASK_WIDTH-1:0] o_wmask1,
  output logic [ADDR_WIDTH-1:0]  o_addr1,
  output logic [DATA_WIDTH-1:0]  o_din1,
  input  logic [DATA_WIDTH-1:0]  i_dout0,
  input  logic [DATA_WIDTH-1:0]  i_dout1
);

  scan_state_e           r_state;
  scan_state_e           w_state_nxt;
  logic [SCAN_LEN-1:0]   r_sreg;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [DATA_WIDTH-1:0] r_dout0_q;
  logic [DATA_WIDTH-1:0] r_dout1_q;
  logic                  r_frame_err;
  logic                  w_armed;
  logic                  w_access;
  logic                  w_load_ok;
  logic                  w_err_set;

  // A full frame must be in and shifting stopped before a strobe is honoured.
  assign w_armed   = (r_state == ST_IDLE) && (r_cnt >= CNT_FULL) && !i_scan_en;
  assign w_load_ok = (r_state == ST_IDLE) && i_sram_load;

  always_comb begin
    w_state_nxt = r_state;
    w_access    = 1'b0;
    w_err_set   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!i_global_csb) begin
          if (w_armed) begin
            w_access    = 1'b1;
            w_state_nxt = ST_CAPTURE;
          end else begin
            w_err_set = 1'b1;
          end
        end
      end
      ST_CAPTURE: begin
        w_state_nxt = ST_IDLE;
        if (i_sram_load || !i_global_csb) w_err_set = 1'b1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sreg <= '0;
    end else if (w_load_ok) begin
      r_sreg[DIN0_MSB:DIN0_LSB] <= r_dout0_q;
      r_sreg[DIN1_MSB:DIN1_LSB] <= r_dout1_q;
    end else if (i_scan_en) begin
      r_sreg <= {r_sreg[SCAN_LEN-2:0], i_scan_in};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (w_access || w_load_ok) begin
      r_cnt <= '0;
    end else if (i_scan_en && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_dout0_q <= '0;
      r_dout1_q <= '0;
    end else if (r_state == ST_CAPTURE) begin
      r_dout0_q <= i_dout0;
      r_dout1_q <= i_dout1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset)        r_frame_err <= 1'b0;
    else if (w_err_set) r_frame_err <= 1'b1;
  end

  assign o_scan_out  = r_sreg[SCAN_LEN-1];
  assign o_frame_err = r_frame_err;

  // Chip selects only go active in the cycle that closes on the access edge.
  assign o_sram_sel = r_sreg[SEL_MSB:SEL_LSB];
  assign o_csb0     = r_sreg[CSB0_BIT] | i_global_csb | ~w_armed;
  assign o_web0     = r_sreg[WEB0_BIT];
  assign o_wmask0   = r_sreg[WMASK0_MSB:WMASK0_LSB];
  assign o_addr0    = r_sreg[ADDR0_MSB:ADDR0_LSB];
  assign o_din0     = r_sreg[DIN0_MSB:DIN0_LSB];
  assign o_csb1     = r_sreg[CSB1_BIT] | i_global_csb | ~w_armed;
  assign o_web1     = r_sreg[WEB1_BIT];
  assign o_wmask1   = r_sreg[WMASK1_MSB:WMASK1_LSB];
  assign o_addr1    = r_sreg[ADDR1_MSB:ADDR1_LSB];
  assign o_din1     = r_sreg[DIN1_MSB:DIN1_LSB];

endmodule

// File: tb/tb_gpio_scan_ctrl.sv
// Directed bench for gpio_scan_ctrl with a small behavioural dual-port SRAM.
module tb_gpio_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset, scan_en, scan_in, sram_load, global_csb;
  logic        scan_out, frame_err;
  logic [3:0]  sram_sel, wmask0, wmask1;
  logic        csb0, web0, csb1, web1;
  logic [15:0] addr0, addr1;
  logic [31:0] din0, din1, dout0, dout1;

  int n_checks = 0;
  int n_errors = 0;
  int n_edge   = 0;

  logic [31:0] mem [0:15];
  logic        l_csb0 = 1'b1, l_csb1 = 1'b1, l_web0, l_web1;
  logic [15:0] l_addr0, l_addr1;
  logic [31:0] l_din0, l_din1;
  logic [3:0]  l_m0, l_m1;

  always #5 clk = ~clk;

  gpio_scan_ctrl dut (
    .i_clk(clk), .i_reset(reset), .i_scan_en(scan_en), .i_scan_in(scan_in),
    .i_sram_load(sram_load), .i_global_csb(global_csb),
    .o_scan_out(scan_out), .o_frame_err(frame_err), .o_sram_sel(sram_sel),
    .o_csb0(csb0), .o_web0(web0), .o_wmask0(wmask0), .o_addr0(addr0), .o_din0(din0),
    .o_csb1(csb1), .o_web1(web1), .o_wmask1(wmask1), .o_addr1(addr1), .o_din1(din1),
    .i_dout0(dout0), .i_dout1(dout1)
  );

  // SRAM model: latch the cycle's controls mid-cycle, act on the closing edge.
  always @(negedge clk) begin
    l_csb0 = csb0; l_web0 = web0; l_addr0 = addr0; l_din0 = din0; l_m0 = wmask0;
    l_csb1 = csb1; l_web1 = web1; l_addr1 = addr1; l_din1 = din1; l_m1 = wmask1;
  end

  always @(posedge clk) begin
    if (!l_csb0 || !l_csb1) n_edge++;
    if (!l_csb0) begin
      if (!l_web0) begin
        for (int b = 0; b < 4; b++) if (l_m0[b]) mem[l_addr0[3:0]][8*b +: 8] = l_din0[8*b +: 8];
      end else dout0 <= mem[l_addr0[3:0]];
    end
    if (!l_csb1) begin
      if (!l_web1) begin
        for (int b = 0; b < 4; b++) if (l_m1[b]) mem[l_addr1[3:0]][8*b +: 8] = l_din1[8*b +: 8];
      end else dout1 <= mem[l_addr1[3:0]];
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [111:0] mk(input logic [3:0] sel, input logic [15:0] a0,
      input logic [31:0] d0, input logic c0, input logic w0, input logic [3:0] m0,
      input logic [15:0] a1, input logic [31:0] d1, input logic c1, input logic w1,
      input logic [3:0] m1);
    return {sel, a0, d0, c0, w0, m0, a1, d1, c1, w1, m1};
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic shift_bits(input logic [111:0] f, input int n);
    for (int i = 111; i > 111 - n; i--) begin
      scan_en = 1'b1; scan_in = f[i];
      tick();
    end
    scan_en = 1'b0; scan_in = 1'b0;
  endtask

  task automatic scan_read(output logic [111:0] v);
    for (int i = 111; i >= 0; i--) begin
      v[i] = scan_out;
      scan_en = 1'b1; scan_in = 1'b0;
      tick();
    end
    scan_en = 1'b0;
  endtask

  logic [111:0] f_w1, f_w2, f_rd, f_exp, got;
  int e0;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    dout0 = 32'h0; dout1 = 32'h0;
    reset = 1'b1; scan_en = 1'b0; scan_in = 1'b0; sram_load = 1'b0; global_csb = 1'b1;
    #1;
    do_reset();
    #1;
    check("rst_scan_out", scan_out, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_csb0", csb0, 1);
    check("rst_csb1", csb1, 1);
    check("rst_fields", {sram_sel, web0, web1, addr0, addr1, din0, din1, wmask0, wmask1}, 0);

    // Write 3 @ addr1 on port 0
    f_w1 = mk(4'd3, 16'd1, 32'h3, 1'b0, 1'b0, 4'hF, 16'd0, 32'd0, 1'b1, 1'b0, 4'h0);
    shift_bits(f_w1, 112);
    check("w1_csb0_no_strobe", csb0, 1);
    global_csb = 1'b0; #1;
    check("w1_csb0", csb0, 0);
    check("w1_web0", web0, 0);
    check("w1_addr0", addr0, 1);
    check("w1_din0", din0, 3);
    check("w1_sel", sram_sel, 3);
    check("w1_csb1", csb1, 1);
    tick(); global_csb = 1'b1; #1;
    check("w1_csb0_capture", csb0, 1);
    tick();
    check("w1_edges", n_edge, 1);
    check("w1_mem", mem[1], 32'h3);

    // Write 24 @ addr2 on port 1
    f_w2 = mk(4'd3, 16'd0, 32'd0, 1'b1, 1'b0, 4'h0, 16'd2, 32'd24, 1'b0, 1'b0, 4'hF);
    shift_bits(f_w2, 112);
    global_csb = 1'b0; #1;
    check("w2_csb1", csb1, 0);
    check("w2_addr1", addr1, 2);
    check("w2_din1", din1, 24);
    check("w2_csb0", csb0, 1);
    tick(); global_csb = 1'b1;
    tick();
    check("w2_mem", mem[2], 32'd24);

    // Read back both ports, load at t+2, scan out from t+3
    f_rd = mk(4'd3, 16'd1, 32'd0, 1'b0, 1'b1, 4'h0, 16'd2, 32'd0, 1'b0, 1'b1, 4'h0);
    shift_bits(f_rd, 112);
    global_csb = 1'b0;
    tick(); global_csb = 1'b1;
    tick();
    sram_load = 1'b1;
    tick(); sram_load = 1'b0;
    scan_read(got);
    f_exp = mk(4'd3, 16'd1, 32'd3, 1'b0, 1'b1, 4'h0, 16'd2, 32'd24, 1'b0, 1'b1, 4'h0);
    check("rd_frame", got, f_exp);
    check("rd_frame_err", frame_err, 0);

    // Load and shift in the same IDLE cycle: load wins
    sram_load = 1'b1; scan_en = 1'b1; scan_in = 1'b1;
    tick(); sram_load = 1'b0; scan_en = 1'b0; scan_in = 1'b0;
    scan_read(got);
    f_exp = mk(4'd0, 16'd0, 32'd3, 1'b0, 1'b0, 4'h0, 16'd0, 32'd24, 1'b0, 1'b0, 4'h0);
    check("load_over_shift", got, f_exp);

    // Short frame
    do_reset();
    e0 = n_edge;
    shift_bits(f_w1, 50);
    global_csb = 1'b0; #1;
    check("short_csb", {csb0, csb1}, 2'b11);
    tick(); global_csb = 1'b1;
    check("short_err", frame_err, 1);
    tick();
    check("short_edges", n_edge - e0, 0);

    // Strobe held low for two cycles
    do_reset();
    e0 = n_edge;
    shift_bits(mk(4'd1, 16'd5, 32'h55, 1'b0, 1'b0, 4'hF, 16'd0, 32'd0, 1'b1, 1'b0, 4'h0), 112);
    global_csb = 1'b0; #1;
    check("dbl_csb0_first", csb0, 0);
    tick();
    check("dbl_csb0_second", csb0, 1);
    tick(); global_csb = 1'b1;
    tick();
    check("dbl_edges", n_edge - e0, 1);
    check("dbl_err", frame_err, 1);

    // scan_en together with strobe
    do_reset();
    e0 = n_edge;
    shift_bits(f_w1, 112);
    scan_en = 1'b1; global_csb = 1'b0; #1;
    check("scanen_csb0", csb0, 1);
    tick(); scan_en = 1'b0; global_csb = 1'b1;
    tick();
    check("scanen_err", frame_err, 1);
    check("scanen_edges", n_edge - e0, 0);

    // sram_load in CAPTURE is ignored
    do_reset();
    shift_bits(f_rd, 112);
    global_csb = 1'b0;
    tick(); global_csb = 1'b1; sram_load = 1'b1;
    tick(); sram_load = 1'b0;
    check("capload_err", frame_err, 1);
    scan_read(got);
    check("capload_frame", got, f_rd);

    // Reset during CAPTURE (dout_q currently holds 3/24)
    shift_bits(f_rd, 112);
    global_csb = 1'b0;
    tick(); global_csb = 1'b1; reset = 1'b1;
    tick(); reset = 1'b0; #1;
    check("rcap_scan_out", scan_out, 0);
    check("rcap_err", frame_err, 0);
    check("rcap_csb", {csb0, csb1}, 2'b11);
    check("rcap_fields", {sram_sel, web0, web1, addr0, addr1, din0, din1, wmask0, wmask1}, 0);
    global_csb = 1'b0; #1;
    check("rcap_cnt_cleared", {csb0, csb1}, 2'b11);
    tick(); global_csb = 1'b1;
    check("rcap_strobe_err", frame_err, 1);
    sram_load = 1'b1;
    tick(); sram_load = 1'b0;
    scan_read(got);
    check("rcap_dout_q", got, 112'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/gpio_scan_ctrl.md
# gpio_scan_ctrl

On-chip responder for the GPIO scan protocol that the test bench drives. It shifts in a 112-bit command frame on `scan_in` under `scan_en` and decodes it into dual-port SRAM control (macro select, two ports of csb/web/wmask/addr/din). On a `global_csb` strobe it fires one SRAM access, then captures both read ports. On `sram_load` it loads the captured read data into the frame so it can be shifted out on `scan_out`. It sits between the GPIO pad mux and the SRAM macro select/mux logic.

## Interface
- `SEL_WIDTH`, 4, macro select width
- `ADDR_WIDTH`, 16, per-port address width
- `DATA_WIDTH`, 32, per-port data width
- `WMASK_WIDTH`, 4, per-port write mask width
- Derived constant: frame length `SCAN_LEN = SEL_WIDTH + 2*(ADDR_WIDTH+DATA_WIDTH+2+WMASK_WIDTH)` = 112.
- `clk  in  1` — single clock, GPIO clock domain.
- `reset  in  1` — synchronous, active-high.
- `scan_en  in  1` — shift enable.
- `scan_in  in  1` — serial frame input, MSB first.
- `sram_load  in  1` — load captured dout into the frame's din fields.
- `global_csb  in  1` — active-low access strobe.
- `scan_out  out  1` — serial frame output (frame MSB).
- `frame_err  out  1` — sticky protocol-error flag.
- `sram_sel  out  SEL_WIDTH` — macro select.
- `csb0, web0  out  1 each` — port 0 controls.
- `wmask0  out  WMASK_WIDTH` — port 0 write mask.
- `addr0  out  ADDR_WIDTH` — port 0 address.
- `din0  out  DATA_WIDTH` — port 0 write data.
- `csb1, web1, wmask1, addr1, din1  out` — same as port 0, for port 1.
- `dout0, dout1  in  DATA_WIDTH` — read data from the selected macro.

## Operation
- Frame layout, MSB→LSB: sel, addr0, din0, csb0, web0, wmask0, addr1, din1, csb1, web1, wmask1. `sreg[111]` is the first bit shifted in.
- Shift register priority: reset > `sram_load` (accepted in IDLE only) > `scan_en` shift > hold.
- Shift: `sreg <= {sreg[110:0], scan_in}`. `scan_out = sreg[111]` (registered; no extra flop).
- Load: din0 field <= `dout0_q`, din1 field <= `dout1_q`. All other fields are unchanged.
- Bit counter `cnt` (7 bits) counts shifts and saturates at 127. It clears on reset, on an accepted access and on an accepted load.
- `armed` = state is IDLE && `cnt` >= 112 && !`scan_en`.
- FSM states:
  - IDLE: if `global_csb`==0 && `armed` → ACCESS edge taken, go to CAPTURE. If `global_csb`==0 && !`armed` → set `frame_err`, stay in IDLE.
  - CAPTURE: `dout0_q <= dout0`, `dout1_q <= dout1`, go to IDLE.
- SRAM outputs are driven combinationally from the frame fields. `csbN = csbN_field | global_csb | !armed`. So the SRAM sees an active chip select only in the cycle whose closing edge is the access edge.
- `frame_err` is also set by `sram_load` in CAPTURE (the load is ignored) and by `global_csb`==0 in CAPTURE. It clears only on reset.

## Timing
- Reset values:
  - `sreg`, `cnt`, `dout*_q` = 0; state = IDLE; `frame_err` = 0; `scan_out` = 0.
  - `csb0` = `csb1` = 1 (forced by !`armed`); `web*` = 0; `sel`, `addr*`, `din*`, `wmask*` = 0.
- Cycle t: `global_csb`=0 with `armed` → SRAM samples at the end of t.
- Cycle t+1: CAPTURE; `dout` is sampled at the end of t+1.
- Earliest accepted `sram_load` is t+2. The first scan-out bit is visible on `scan_out` in t+3, before any shift.
- `global_csb` held low for more than one cycle gives one access. The second low cycle lands in CAPTURE and sets `frame_err`.
- `scan_en` and `global_csb`=0 in the same cycle: no access, `frame_err` set.
- `sram_load` and `scan_en` in the same IDLE cycle: the load wins and no shift occurs.
- Reset mid-CAPTURE: capture is abandoned, `dout*_q` = 0, and `csb*` is forced high in the same cycle reset is sampled.

## Structure
- Package `gpio_scan_pkg` holds:
  - width constants and `SCAN_LEN`;
  - field MSB/LSB offset constants;
  - FSM state enum {IDLE, CAPTURE}.
- No sub-module: the shift register, counter and 2-state FSM stay in one module.

## Test plan
- Write: shift the frame (sel=3, addr0=1, din0=32'h0000_0003, csb0=0, web0=0, wmask0=4'hF, csb1=1), then `global_csb` low for 1 cycle → at the access edge `csb0`=0, `web0`=0, `addr0`=1, `din0`=3, `sram_sel`=3, `csb1`=1.
- Read-back: after writes of 3 @addr1 and 24 @addr2, shift a read frame (web0=web1=1, addr0=1, addr1=2), strobe, `sram_load` at t+2 → the 112 bits scanned out match the frame with din0=3, din1=24.
- Short frame: 50 shifts, then `global_csb`=0 → `csb0`=`csb1`=1 throughout and `frame_err`=1.
- `global_csb` low for 2 cycles → exactly one access edge and `frame_err`=1.
- `sram_load` in CAPTURE → ignored, `frame_err`=1; `sreg` din fields unchanged.
- `reset` asserted in CAPTURE → next cycle all outputs at their reset values and `cnt`=0.
